// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer handshakes and FIFO write-port signals for fifo_wr_arbiter.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 16,
    parameter int FIFO_PTR = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      fifo_full;
    logic [FIFO_PTR:0]         room_avail;
    logic [NUM_REQ*16-1:0]     stat_cnt;

    modport master (
        input  req_valid, req_data, fifo_full, room_avail,
        output req_ready, grant, wr_en, wr_data, stat_cnt
    );

    modport slave (
        output req_valid, req_data, fifo_full, room_avail,
        input  req_ready, grant, wr_en, wr_data, stat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional per-producer accept counters enabled by defining FIFO_WR_ARB_STAT_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int FIFO_D    = 32,
    parameter int FIFO_PTR  = $clog2(FIFO_D),
    parameter int MAX_BURST = 8
) (
    input  logic                wr_clk,
    input  logic                rst_n,
    fifo_wr_arbiter_if.master   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    owner_reg, owner_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [7:0]          beat_cnt_reg, beat_cnt_next;
    logic                wr_en_reg, wr_en_next;
    logic [DATA_W-1:0]   wr_data_reg, wr_data_next;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W:0]      cand;
    logic [FIFO_PTR:0]   room_eff;
    logic                space;
    logic                owner_valid;
    logic                accept;
    logic [DATA_W-1:0]   owner_data;
    logic [IDX_W-1:0]    owner_inc;

    // Out-of-range room counts are clamped to the FIFO depth.
    assign room_eff    = (bus.room_avail > (FIFO_PTR+1)'(FIFO_D)) ? (FIFO_PTR+1)'(FIFO_D)
                                                                  : bus.room_avail;
    // The write already on wr_en has not been counted in room_avail yet.
    assign space       = !bus.fifo_full && (room_eff > {{FIFO_PTR{1'b0}}, wr_en_reg});
    assign owner_valid = bus.req_valid[owner_reg];
    assign owner_data  = bus.req_data[owner_reg*DATA_W +: DATA_W];
    assign accept      = (state_reg == BURST) && owner_valid && space;
    assign owner_inc   = (owner_reg == IDX_W'(NUM_REQ-1)) ? '0 : owner_reg + 1'b1;

    // Scan from rr_ptr downwards in priority so the closest valid index wins last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_reg;
        cand       = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (bus.req_valid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        wr_en_next    = 1'b0;
        wr_data_next  = wr_data_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    owner_next    = pick_idx;
                    beat_cnt_next = 8'd0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    wr_en_next    = 1'b1;
                    wr_data_next  = owner_data;
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    if (beat_cnt_next == 8'(MAX_BURST)) begin
                        state_next  = IDLE;
                        rr_ptr_next = owner_inc;
                    end
                end else if (!owner_valid) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            wr_en_reg    <= wr_en_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    always_comb begin
        bus.grant     = '0;
        bus.req_ready = '0;
        if (state_reg == BURST) begin
            bus.grant[owner_reg]     = 1'b1;
            bus.req_ready[owner_reg] = space;
        end
    end

    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_data = wr_data_reg;

`ifdef FIFO_WR_ARB_STAT_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge wr_clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (accept && (owner_reg == IDX_W'(gi)) && (cnt_reg != 16'hFFFF))
                    cnt_reg <= cnt_reg + 16'd1;
            end
            assign bus.stat_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`else
    assign bus.stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed + random producers against a
// queue-based reference model of arbitration and an occupancy model of the FIFO.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int FD = 32;
    localparam int FP = 5;
    localparam int MB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .FIFO_PTR(FP)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .FIFO_D(FD), .FIFO_PTR(FP), .MAX_BURST(MB)
    ) dut (
        .wr_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Producer word queues as flat arrays with head/tail indices.
    logic [15:0] src [N][1024];
    int          head [N];
    int          tail [N];
    logic [N-1:0] en;

    // Reference model state: -1 owner means no burst in progress.
    int          m_owner;
    int          m_rr;
    int          m_beats;
    logic        m_wr_en;
    logic [15:0] m_wr_data;
    int          m_stat [N];
    int          fcount;
    logic        rd_now;
    int          rd_mode;   // 0 no reads, 1 read whenever non-empty, 2 random reads
    int          wr_seen;

    function automatic bit valid(input int p);
        return en[p] && (head[p] != tail[p]);
    endfunction

    task automatic push(input int p, input logic [15:0] w);
        src[p][tail[p]] = w;
        tail[p]++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            bus.req_valid[p] = valid(p);
            bus.req_data[p*DW +: DW] = (head[p] != tail[p]) ? src[p][head[p]] : 16'h0000;
        end
        bus.fifo_full  = (fcount == FD);
        bus.room_avail = 6'(FD - fcount);
        rd_now = (fcount > 0) && ((rd_mode == 1) || ((rd_mode == 2) && ($urandom_range(1) == 1)));
    endtask

    function automatic logic [63:0] exp_stat();
        logic [63:0] v;
        v = '0;
`ifdef FIFO_WR_ARB_STAT_EN
        for (int p = 0; p < N; p++) v[p*16 +: 16] = 16'(m_stat[p]);
`endif
        return v;
    endfunction

    // One clock: check current outputs, advance the model, cross the edge, redrive inputs.
    task automatic cycle();
        bit          space;
        bit          leave;
        int          pop;
        int          cand;
        logic        nxt_wr_en;
        logic [15:0] nxt_data;
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        #1;
        space   = (fcount != FD) && ((FD - fcount) > (m_wr_en ? 1 : 0));
        e_grant = '0;
        e_ready = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = space;
        end
        check("grant",    64'(bus.grant),     64'(e_grant));
        check("req_ready",64'(bus.req_ready), 64'(e_ready));
        check("wr_en",    64'(bus.wr_en),     64'(m_wr_en));
        check("wr_data",  64'(bus.wr_data),   64'(m_wr_data));
        check("stat_cnt", bus.stat_cnt,       exp_stat());
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            $display("write data=%h grant=%b room=%0d", bus.wr_data, bus.grant, bus.room_avail);
        end

        pop       = -1;
        leave     = 0;
        nxt_wr_en = 1'b0;
        nxt_data  = m_wr_data;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                cand = (m_rr + k) % N;
                if (m_owner < 0 && valid(cand)) begin
                    m_owner = cand;
                    m_beats = 0;
                end
            end
        end else begin
            if (valid(m_owner) && space) begin
                nxt_wr_en = 1'b1;
                nxt_data  = src[m_owner][head[m_owner]];
                pop       = m_owner;
                m_beats++;
                if (m_stat[m_owner] < 16'hFFFF) m_stat[m_owner]++;
                if (m_beats == MB) leave = 1;
            end else if (!valid(m_owner)) begin
                leave = 1;
            end
            if (leave) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end

        @(posedge clk);
        if (pop >= 0) head[pop]++;
        fcount    = fcount + (m_wr_en ? 1 : 0) - (rd_now ? 1 : 0);
        m_wr_en   = nxt_wr_en;
        m_wr_data = nxt_data;
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_grant",   64'(bus.grant),     64'd0);
        check("rst_ready",   64'(bus.req_ready), 64'd0);
        check("rst_wr_en",   64'(bus.wr_en),     64'd0);
        check("rst_wr_data", 64'(bus.wr_data),   64'd0);
        check("rst_stat",    bus.stat_cnt,       64'd0);
        m_owner   = -1;
        m_rr      = 0;
        m_beats   = 0;
        m_wr_en   = 1'b0;
        m_wr_data = '0;
        fcount    = 0;
        for (int p = 0; p < N; p++) m_stat[p] = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive();
    endtask

    task automatic flush_queues();
        for (int p = 0; p < N; p++) head[p] = tail[p];
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            head[p]   = 0;
            tail[p]   = 0;
            m_stat[p] = 0;
        end
        en      = '0;
        fcount  = 0;
        rd_mode = 1;
        wr_seen = 0;
        m_owner = -1;
        m_rr    = 0;
        m_beats = 0;
        m_wr_en = 1'b0;
        m_wr_data = '0;
        drive();
        do_reset();

        // Single producer 2, two full bursts with an arbitration gap between them.
        for (int n = 0; n < 16; n++) push(2, 16'h0200 + 16'(n));
        en = 4'b0100;
        drive();
        run(24);

        // All producers competing, reads keep the FIFO near empty.
        for (int p = 0; p < N; p++)
            for (int n = 0; n < 16; n++) push(p, 16'($urandom));
        en = 4'b1111;
        drive();
        run(80);

        // FIFO fills with no reads: exactly FD writes, then one read admits one more.
        en = 4'b0000;
        drive();
        run(40);
        for (int n = 0; n < 40; n++) push(0, 16'hA000 + 16'(n));
        rd_mode = 0;
        en      = 4'b0001;
        wr_seen = 0;
        drive();
        run(50);
        check("fill_writes", 64'(wr_seen), 64'(FD));
        check("full_flag",   64'(bus.fifo_full), 64'd1);
        rd_mode = 1;
        drive();
        cycle();
        rd_mode = 0;
        drive();
        wr_seen = 0;
        run(20);
        check("refill_writes", 64'(wr_seen), 64'd1);

        // Drain, then producer 1 stops after 3 words while producer 3 waits.
        rd_mode = 1;
        en      = 4'b0000;
        drive();
        run(45);
        flush_queues();
        for (int n = 0; n < 3; n++) push(1, 16'h1100 + 16'(n));
        for (int n = 0; n < 5; n++) push(3, 16'h3300 + 16'(n));
        en = 4'b1010;
        drive();
        run(20);

        // Random producers, enables and FIFO reads.
        rd_mode = 2;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(2) == 0 && tail[p] < 1000) push(p, 16'($urandom));
                if ($urandom_range(7) == 0) en[p] = ~en[p];
            end
            drive();
            cycle();
        end

        // Reset in the middle of a burst, then arbitration restarts at producer 0.
        rd_mode = 1;
        en      = 4'b0000;
        drive();
        run(50);
        flush_queues();
        for (int n = 0; n < 10; n++) begin
            push(0, 16'h0A00 + 16'(n));
            push(2, 16'h2A00 + 16'(n));
        end
        en = 4'b0101;
        drive();
        run(3);
        do_reset();
        run(40);

        // Counter check: 20 words from producer 0, 5 from producer 1.
        do_reset();
        flush_queues();
        for (int n = 0; n < 20; n++) push(0, 16'h0C00 + 16'(n));
        for (int n = 0; n < 5; n++)  push(1, 16'h1C00 + 16'(n));
        en = 4'b0011;
        drive();
        run(45);
`ifdef FIFO_WR_ARB_STAT_EN
        check("stat_p0", 64'(bus.stat_cnt[15:0]),  64'd20);
        check("stat_p1", 64'(bus.stat_cnt[31:16]), 64'd5);
`else
        check("stat_p0", 64'(bus.stat_cnt[15:0]),  64'd0);
        check("stat_p1", 64'(bus.stat_cnt[31:16]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
